nand_unit: RTL and testbench
============================

Name: nand_unit

Overview:
- Registered bitwise NAND unit: result = ~(a & b) over WIDTH bits, plus status flags and a transaction counter.
- Sits in the binary-logic datapath as a leaf operator behind a valid/ready stream.
- Single-entry output register gives 1-cycle latency and full throughput under backpressure-free operation.

Parameters:
- WIDTH, 4, operand/result bit width (>=1)
- CNT_W, 8, width of the completed-operation counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- in_valid  in  1  operands valid this cycle
- in_ready  out  1  unit can accept operands
- result  out  WIDTH  registered ~(a & b)
- out_valid  out  1  result holds an unconsumed value
- out_ready  in  1  downstream accepts result
- zero_flag  out  1  registered result == 0
- ones_flag  out  1  registered result == all ones
- op_count  out  CNT_W  number of accepted operations, mod 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, asserted at any time, immediately forces:
  - result = 0, out_valid = 0, zero_flag = 0, ones_flag = 0, op_count = 0.
  - Reset mid-operation discards any pending result.
- in_ready = !out_valid || out_ready. This is combinational; there is no combinational path from a or b.
- Accept occurs when in_valid && in_ready at a rising edge. On the same edge:
  - result <= ~(a & b), bitwise.
  - out_valid <= 1.
  - zero_flag and ones_flag are computed from the new result.
  - op_count increments.
- Latency is 1 cycle: the result is visible the cycle after acceptance.
- Drain occurs when out_valid && out_ready && !(in_valid && in_ready): out_valid <= 0. result and flags hold their last values.
- Simultaneous drain and accept: the new result replaces the old one; out_valid stays 1. This gives full throughput.
- When out_valid=1 and out_ready=0: in_ready=0. result, flags and op_count are stable.
- in_valid is ignored while in_ready=0. No operand is lost, provided the producer holds its operands.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- Widths: all operations are bitwise at WIDTH. No carries, no sign handling.
- X on a or b while in_valid=0 must not propagate into the registers.

Optional Feature:
- Macro NAND_UNIT_PARITY_EN.
- When defined:
  - Adds output port parity (out, 1) = XOR-reduction of result.
  - parity is registered on the same edge as result and resets to 0.
  - parity is held during stalls, like the flags.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package nand_pkg holds:
  - localparam defaults NAND_WIDTH_DEF=4 and NAND_CNT_W_DEF=8.
  - A typedef for the flag bundle {zero, ones}.
- One natural sub-module, nand_bitwise_core:
  - Purely combinational, WIDTH-parameterised.
  - Outputs ~(a&b), zero detect and ones detect, feeding nand_unit's registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> result=0000, out_valid=0, flags=0, op_count=0 immediately, without waiting for a clock edge.
- Basic NAND: a=1010, b=1100, in_valid=1, out_ready=1 -> next cycle result=0111, out_valid=1, zero_flag=0, ones_flag=0, op_count=1.
- All-ones case: a=1111, b=0000 -> result=1111, ones_flag=1. Then a=1111, b=1111 -> result=0000, zero_flag=1.
- Backpressure: out_ready=0 after an accept -> in_ready=0. A new a/b with in_valid=1 is ignored; result stays 0111 for 5 cycles. Then out_ready=1 -> the pending operand is accepted.
- Throughput: out_ready=1, 8 back-to-back ops with a=i, b=~i -> 8 results, each 1111, on consecutive cycles; op_count=8.
- Wrap and parity: CNT_W=2, 5 accepts -> op_count=1. With NAND_UNIT_PARITY_EN defined, result 0111 -> parity=1.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared defaults and flag bundle for the registered NAND unit and its core.
package nand_pkg;

  localparam int NAND_WIDTH_DEF = 4;
  localparam int NAND_CNT_W_DEF = 8;

  typedef struct packed {
    logic zero;
    logic ones;
  } nand_flags_t;

endpackage

// File: rtl/nand_bitwise_core.sv
// Combinational NAND core: bitwise ~(a & b) plus all-zero / all-one detection.
module nand_bitwise_core
  import nand_pkg::*;
#(
  parameter int WIDTH = NAND_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output nand_flags_t      flags
);

  assign result     = ~(a & b);
  assign flags.zero = (result == '0);
  assign flags.ones = (result == '1);

endmodule

// File: rtl/nand_unit.sv
// Registered NAND leaf operator behind a valid/ready stream with flags and op counter.
// Define NAND_UNIT_PARITY_EN to add a registered XOR-reduction 'parity' output.
module nand_unit
  import nand_pkg::*;
#(
  parameter int WIDTH = NAND_WIDTH_DEF,
  parameter int CNT_W = NAND_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero_flag,
  output logic             ones_flag,
  output logic [CNT_W-1:0] op_count
`ifdef NAND_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] next_result;
  nand_flags_t      next_flags;
  nand_flags_t      flags_q;
  logic             accept;

  nand_bitwise_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .result (next_result),
    .flags  (next_flags)
  );

  // The slot frees up in the same cycle it drains, so accept and drain can overlap.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else if (accept) begin
      result    <= next_result;
      flags_q   <= next_flags;
      out_valid <= 1'b1;
      op_count  <= op_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero_flag = flags_q.zero;
  assign ones_flag = flags_q.ones;

`ifdef NAND_UNIT_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^next_result;
    end
  end
`endif

endmodule

// File: tb/tb_nand_unit.sv
// Self-checking bench for nand_unit: vector table, hand sequences and randomized run vs a reference model.
module tb_nand_unit;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic [W-1:0]  result;
  logic          out_valid;
  logic          zero_flag;
  logic          ones_flag;
  logic [CW-1:0] op_count;

  logic          w_in_ready;
  logic [W-1:0]  w_result;
  logic          w_out_valid;
  logic          w_zero_flag;
  logic          w_ones_flag;
  logic [1:0]    w_op_count;

`ifdef NAND_UNIT_PARITY_EN
  logic parity;
  logic w_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_result;
  logic         m_valid;
  int           m_count;

  nand_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero_flag (zero_flag),
    .ones_flag (ones_flag),
    .op_count  (op_count)
`ifdef NAND_UNIT_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  // Narrow-counter instance shares stimulus so wrap-around is exercised continuously.
  nand_unit #(.WIDTH(W), .CNT_W(2)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .result    (w_result),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .zero_flag (w_zero_flag),
    .ones_flag (w_ones_flag),
    .op_count  (w_op_count)
`ifdef NAND_UNIT_PARITY_EN
    ,
    .parity    (w_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         iv;
    logic         ordy;
    logic [W-1:0] exp_result;
    logic         exp_valid;
    logic         exp_zero;
    logic         exp_ones;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [W-1:0] refNand(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (x[i] == 1'b1 && y[i] == 1'b1) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic refParity(input logic [W-1:0] x);
    int ones = 0;
    for (int i = 0; i < W; i++) if (x[i]) ones++;
    return logic'(ones % 2);
  endfunction

  task automatic checkModel();
    checkOutput("result", result, m_result);
    checkOutput("out_valid", out_valid, m_valid);
    checkOutput("zero_flag", zero_flag, (m_valid || m_count != 0) ? (m_result == 0) : 1'b0);
    checkOutput("ones_flag", ones_flag, (m_count != 0 || m_valid) ? (m_result == {W{1'b1}}) : 1'b0);
    checkOutput("op_count", op_count, m_count % 256);
    checkOutput("wrap_op_count", w_op_count, m_count % 4);
    checkOutput("wrap_result", w_result, m_result);
`ifdef NAND_UNIT_PARITY_EN
    checkOutput("parity", parity, refParity(m_result));
`endif
  endtask

  // One clock of stimulus; the model applies the stream rules at the edge.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                               input logic tiv, input logic tor);
    logic acc;
    @(negedge clk);
    a = ta;
    b = tb_b;
    in_valid = tiv;
    out_ready = tor;
    #1;
    checkOutput("in_ready", in_ready, (!m_valid || tor));
    acc = tiv && (!m_valid || tor);
    @(posedge clk);
    if (acc) begin
      m_result = refNand(ta, tb_b);
      m_valid  = 1'b1;
      m_count  = m_count + 1;
    end else if (tor) begin
      m_valid = 1'b0;
    end
    #1;
    checkModel();
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_result", result, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_zero_flag", zero_flag, 0);
    checkOutput("rst_ones_flag", ones_flag, 0);
    checkOutput("rst_op_count", op_count, 0);
`ifdef NAND_UNIT_PARITY_EN
    checkOutput("rst_parity", parity, 0);
`endif
    m_result = '0;
    m_valid  = 1'b0;
    m_count  = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'b1010, 4'b1100, 1'b1, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'b0011, 4'b0101, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0};

    m_result = '0;
    m_valid  = 1'b0;
    m_count  = 0;
    doReset();

    // Basic NAND, flag extremes, drain and stall from the table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].iv, vecs[i].ordy);
      checkOutput("vec_result", result, vecs[i].exp_result);
      checkOutput("vec_out_valid", out_valid, vecs[i].exp_valid);
      checkOutput("vec_zero_flag", zero_flag, vecs[i].exp_zero);
      checkOutput("vec_ones_flag", ones_flag, vecs[i].exp_ones);
    end
    checkOutput("vec_op_count", op_count, 4);

    // Backpressure: stalled operand must wait, then be taken once out_ready rises.
    doReset();
    applyStimulus(4'b1010, 4'b1100, 1'b1, 1'b1);
    checkOutput("bp_first", result, 4'b0111);
`ifdef NAND_UNIT_PARITY_EN
    checkOutput("parity_0111", parity, 1);
`endif
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
      checkOutput("bp_hold", result, 4'b0111);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
    checkOutput("bp_release", result, 4'b1111);
    checkOutput("bp_count", op_count, 2);

    // Reset while a result is pending.
    applyStimulus(4'b0110, 4'b0110, 1'b1, 1'b0);
    checkOutput("pre_rst_valid", out_valid, 1);
    doReset();

    // Back-to-back throughput.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(W'(i), ~W'(i), 1'b1, 1'b1);
      checkOutput("tp_result", result, 4'b1111);
      checkOutput("tp_valid", out_valid, 1);
    end
    checkOutput("tp_count", op_count, 8);
    checkOutput("tp_wrap_count", w_op_count, 0);

    // Narrow counter wrap.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'b0101, 4'b0011, 1'b1, 1'b1);
    checkOutput("wrap_count_5", w_op_count, 1);
    checkOutput("wide_count_5", op_count, 5);

    // Randomized traffic including long runs that wrap the wide counter.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
